pixel_write_buffer: RTL
=======================

PIXEL_WRITE_BUFFER -- requirements
Module: pixel_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter VGA_WIDTH_C, default 160, visible pixel columns.
REQ-003 SHALL have parameter VGA_HEIGHT_C, default 120, visible pixel rows.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_valid  input  1  pixel write request from line drawer, one pixel per cycle.
REQ-007 SHALL have port write_x_pos  input  8  pixel column, unsigned.
REQ-008 SHALL have port write_y_pos  input  7  pixel row, unsigned.
REQ-009 SHALL have port pixel_color  input  3  RGB colour, sampled with wr_valid.
REQ-010 SHALL have port fb_ready  input  1  framebuffer port can accept a write this cycle.
REQ-011 SHALL have port fb_wr_en  output  1  framebuffer write strobe.
REQ-012 SHALL have port fb_wr_addr  output  15  linear address y*VGA_WIDTH_C+x.
REQ-013 SHALL have port fb_wr_data  output  3  colour for fb_wr_addr.
REQ-014 SHALL have port clear_overflow  input  1  clears sticky overflow.
REQ-015 SHALL have port empty  output  1  FIFO and input pipeline hold no pixels.
REQ-016 SHALL have port almost_full  output  1  FIFO count >= DEPTH-2 (covers two in-flight stages).
REQ-017 SHALL have port overflow  output  1  sticky: a valid pixel was dropped for lack of space.

Function
REQ-018 Stage 1 SHALL register wr_valid, x, y, colour each cycle; in-bounds flag = x<VGA_WIDTH_C and y<VGA_HEIGHT_C.
REQ-019 Out-of-bounds pixels SHALL be discarded at stage 1: never stored, never written, never set overflow.
REQ-020 Stage 2 SHALL compute address as (y<<7)+(y<<5)+x in 15 bits (no multiplier), registering {addr, colour} as the FIFO push candidate.
REQ-021 FIFO SHALL be DEPTH entries, circular read/write pointers wrapping DEPTH-1 -> 0, count 0..DEPTH.
REQ-022 fb_wr_en SHALL equal (FIFO not empty) AND fb_ready, combinationally; fb_wr_addr/fb_wr_data SHALL show FIFO head whenever not empty, 0 when empty.
REQ-023 Pop SHALL occur on each rising edge where fb_wr_en=1.
REQ-024 Push SHALL occur when stage-2 candidate valid and (count<DEPTH or pop same cycle); simultaneous push and pop at full SHALL be accepted, count unchanged.
REQ-025 Push at count==DEPTH without pop SHALL drop the pixel and set overflow on that edge.
REQ-026 overflow SHALL stay 1 until clear_overflow=1 on an edge; a drop on the same edge as clear_overflow SHALL leave overflow=1.
REQ-027 Latency SHALL be exactly 2 cycles: wr_valid sampled at edge N -> fb_wr_en high in cycle after edge N+2 when FIFO was empty and fb_ready=1.
REQ-028 Writes SHALL leave in acceptance order; no reordering, no merging of repeated addresses.
REQ-029 empty SHALL be 1 only when count==0 and stage-1/stage-2 valids are 0.
REQ-030 Sustained throughput SHALL be one pixel per cycle when fb_ready held 1.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear pointers, count, stage valids and overflow; fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, almost_full=0, overflow=0, empty=1.
REQ-032 Reset mid-burst SHALL discard all buffered and in-flight pixels; no write SHALL issue for pre-reset pixels after rst_n deasserts.
REQ-033 First wr_valid sampled on first edge after rst_n rises SHALL be accepted normally.

Verification
REQ-034 x=5,y=3,colour=3'b101,fb_ready=1 -> one fb_wr_en pulse 2 cycles later, addr 485, data 3'b101.
REQ-035 x=159,y=119 -> addr 19199; x=160,y=0 and x=0,y=120 -> no write, empty stays 1, overflow 0.
REQ-036 fb_ready=0, 17 consecutive in-bounds pixels -> almost_full at count 14, 17th dropped, overflow=1; then fb_ready=1 -> 16 writes in input order, empty=1 after.
REQ-037 FIFO full, fb_ready=1, new pixel arriving -> pixel accepted, count stays 16, overflow stays 0.
REQ-038 Drop coincident with clear_overflow=1 -> overflow remains 1; next clear_overflow with no drop -> 0.
REQ-039 rst_n pulled low mid-cycle during 8-pixel burst -> outputs 0 immediately, empty=1, no writes after release.

Source files
------------

// File: rtl/pixel_write_buffer_if.sv
// Pixel write buffer bus: line-drawer input, framebuffer write port and status flags.
interface pixel_write_buffer_if;
  logic       wr_valid;
  logic [7:0] write_x_pos;
  logic [6:0] write_y_pos;
  logic [2:0] pixel_color;
  logic       fb_ready;
  logic       clear_overflow;
  logic       fb_wr_en;
  logic [14:0] fb_wr_addr;
  logic [2:0] fb_wr_data;
  logic       empty;
  logic       almost_full;
  logic       overflow;

  modport master (
    output wr_valid, write_x_pos, write_y_pos, pixel_color, fb_ready, clear_overflow,
    input  fb_wr_en, fb_wr_addr, fb_wr_data, empty, almost_full, overflow
  );

  modport slave (
    input  wr_valid, write_x_pos, write_y_pos, pixel_color, fb_ready, clear_overflow,
    output fb_wr_en, fb_wr_addr, fb_wr_data, empty, almost_full, overflow
  );
endinterface

// File: rtl/pixel_write_buffer.sv
// Two-stage pixel pipeline (bounds check, address generation) feeding a FIFO
// that drains into the framebuffer write port whenever it is ready.
module pixel_write_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned VGA_WIDTH_C  = 160,
  parameter int unsigned VGA_HEIGHT_C = 120
) (
  input logic                  clk,
  input logic                  rst_n,
  pixel_write_buffer_if.slave  bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned COL_W  = 3;
  localparam logic [8:0]    X_LIM     = 9'(VGA_WIDTH_C);
  localparam logic [7:0]    Y_LIM     = 8'(VGA_HEIGHT_C);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(DEPTH - 2);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  color;
  } pix_t;

  logic             s1_valid;
  logic [7:0]       s1_x;
  logic [6:0]       s1_y;
  logic [COL_W-1:0] s1_color;
  logic             s2_valid;
  pix_t             s2_pix;

  pix_t             mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty_q;
  logic             afull_q;
  logic             ovf_q;

  logic              in_bounds_c;
  logic              s1_valid_nxt_c;
  logic [ADDR_W-1:0] addr_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic [CW-1:0]     count_nxt_c;
  pix_t              head_c;

  assign in_bounds_c    = ({1'b0, bus.write_x_pos} < X_LIM) && ({1'b0, bus.write_y_pos} < Y_LIM);
  assign s1_valid_nxt_c = bus.wr_valid && in_bounds_c;

  // Stage 1: out-of-bounds pixels never become valid, so they cannot reach the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= s1_valid_nxt_c;
      s1_x     <= bus.write_x_pos;
      s1_y     <= bus.write_y_pos;
      s1_color <= bus.pixel_color;
    end
  end

  // y*160 + x built from shifts: 160 = 128 + 32.
  assign addr_c = (ADDR_W'(s1_y) << 7) + (ADDR_W'(s1_y) << 5) + ADDR_W'(s1_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_pix   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_pix   <= '{addr: addr_c, color: s1_color};
    end
  end

  // A pop frees a slot on the same edge, so a full FIFO still accepts when draining.
  always_comb begin
    pop_c       = (count != '0) && bus.fb_ready;
    push_c      = s2_valid && ((count != CNT_FULL) || pop_c);
    drop_c      = s2_valid && (count == CNT_FULL) && !pop_c;
    count_nxt_c = count;
    head_c      = '0;
    if (push_c && !pop_c) begin
      count_nxt_c = count + CW'(1);
    end else if (pop_c && !push_c) begin
      count_nxt_c = count - CW'(1);
    end
    if (count != '0) begin
      head_c = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
      afull_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt_c;
      // A drop wins over a simultaneous clear so no loss goes unreported.
      if (drop_c) begin
        ovf_q <= 1'b1;
      end else if (bus.clear_overflow) begin
        ovf_q <= 1'b0;
      end
      afull_q <= (count_nxt_c >= CNT_AFULL);
      empty_q <= (count_nxt_c == '0) && !s1_valid_nxt_c && !s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= s2_pix;
    end
  end

  assign bus.fb_wr_en    = pop_c;
  assign bus.fb_wr_addr  = head_c.addr;
  assign bus.fb_wr_data  = head_c.color;
  assign bus.empty       = empty_q;
  assign bus.almost_full = afull_q;
  assign bus.overflow    = ovf_q;

endmodule
